// File: rtl/refresh_monitor_pkg.sv
// Shared state encoding and default timing constants for refresh_monitor.
// Defaults assume a 60 Hz refresh source sampled by a ~30 MHz clk.
package refresh_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_e;

   localparam int DEF_MIN_PERIOD = 495000;
   localparam int DEF_MAX_PERIOD = 505000;
   localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/refresh_sync_edge.sv
// Rising-edge detector for refresh_in; REFRESH_MONITOR_SYNC_EN adds a two-flop
// synchronizer in front. tick_early is the combinational pulse that loads tick.
module refresh_sync_edge (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic refresh_in,
   output logic tick,
   output logic tick_early
);
   logic sample;
   logic sample_ok;
   logic prev_q, prev_d;
   logic armed_q, armed_d;
   logic tick_q, tick_d;

`ifdef REFRESH_MONITOR_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic fill1_q, fill1_d;
   logic fill2_q, fill2_d;

   always_comb begin
      sync1_d = refresh_in;
      sync2_d = sync1_q;
      fill1_d = 1'b1;
      fill2_d = fill1_q;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         fill1_q <= 1'b0;
         fill2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         fill1_q <= fill1_d;
         fill2_q <= fill2_d;
      end
   end

   // fill2_q marks that sync2_q holds a real post-reset sample, not the reset zero
   assign sample    = sync2_q;
   assign sample_ok = fill2_q;
`else
   assign sample    = refresh_in;
   assign sample_ok = 1'b1;
`endif

   // Edges are only accepted once a genuine low has been seen after reset,
   // so a source already high at reset release does not produce a tick.
   always_comb begin
      tick_early = sample & ~prev_q & armed_q;
      tick_d     = tick_early;
      prev_d     = sample;
      armed_d    = armed_q | (sample_ok & ~sample);
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/refresh_monitor.sv
// Measures the refreshIn rising-edge period and tracks lock to the expected rate.
// Define REFRESH_MONITOR_SYNC_EN when refreshIn is asynchronous to clock.
module refresh_monitor
   import refresh_monitor_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int MAX_PERIOD = DEF_MAX_PERIOD,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             refreshIn,
   output logic             tick,
   output logic [WIDTH-1:0] period,
   output logic             periodValid,
   output logic             locked,
   output logic             timeout
);
   // state    | meaning
   // IDLE     | no edge seen since reset
   // ACQUIRE  | counting consecutive in-range periods in good_q
   // LOCKED   | LOCK_COUNT consecutive in-range periods seen
   // LOST     | no edge within MAX_PERIOD clocks; waiting for the next one

   localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_CNT   = WIDTH'(MIN_PERIOD);
   localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_PERIOD);
   localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
   localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_COUNT);

   logic              tick_early;
   mon_state_e        st_q, st_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [WIDTH-1:0]  period_q, period_d;
   logic              valid_q, valid_d;
   logic              locked_q, locked_d;
   logic              timeout_q, timeout_d;
   logic [WIDTH-1:0]  meas;
   logic              in_range;

   refresh_sync_edge u_sync_edge (
      .clk_sys    (clock),
      .rst_b      (reset),
      .refresh_in (refreshIn),
      .tick       (tick),
      .tick_early (tick_early)
   );

   // Everything is decided on tick_early so period/periodValid/locked line up
   // with the registered tick; cnt_q reads 0 in the tick cycle itself.
   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      good_d   = good_q;
      period_d = period_q;
      valid_d  = 1'b0;
      meas     = cnt_q + ONE;
      in_range = (meas >= MIN_CNT) && (meas <= MAX_CNT);

      if (tick_early) begin
         cnt_d = '0;
         case (st_q)
            ST_IDLE, ST_LOST: begin
               st_d   = ST_ACQUIRE;
               good_d = '0;
            end
            ST_ACQUIRE: begin
               period_d = meas;
               valid_d  = 1'b1;
               if (in_range) begin
                  good_d = good_q + GOOD_ONE;
                  if (good_d == LOCK_GOOD) st_d = ST_LOCKED;
               end else begin
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               period_d = meas;
               valid_d  = 1'b1;
               if (!in_range) begin
                  st_d   = ST_ACQUIRE;
                  good_d = '0;
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end else begin
         if (cnt_q != MAX_CNT) cnt_d = cnt_q + ONE;
         if ((st_q == ST_ACQUIRE || st_q == ST_LOCKED) && cnt_q == MAX_CNT) begin
            st_d   = ST_LOST;
            good_d = '0;
         end
      end

      locked_d  = (st_d == ST_LOCKED);
      timeout_d = (st_d == ST_LOST);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q      <= ST_IDLE;
         cnt_q     <= '0;
         good_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         good_q    <= good_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period      = period_q;
   assign periodValid = valid_q;
   assign locked      = locked_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_refresh_monitor.sv
// Scoreboard bench for refresh_monitor: each issued rising edge pushes the
// expected tick record; a negedge monitor pops and compares on every tick.
module tb_refresh_monitor;

   localparam int WIDTH  = 16;
   localparam int MIN_P  = 8;
   localparam int MAX_P  = 12;
   localparam int LOCK_N = 2;
`ifdef REFRESH_MONITOR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   localparam int M_IDLE = 0;
   localparam int M_ACQ  = 1;
   localparam int M_LOCK = 2;
   localparam int M_LOST = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             refreshIn = 1'b0;
   logic             tick;
   logic [WIDTH-1:0] period;
   logic             periodValid;
   logic             locked;
   logic             timeout;

   refresh_monitor #(
      .WIDTH      (WIDTH),
      .MIN_PERIOD (MIN_P),
      .MAX_PERIOD (MAX_P),
      .LOCK_COUNT (LOCK_N)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .refreshIn   (refreshIn),
      .tick        (tick),
      .period      (period),
      .periodValid (periodValid),
      .locked      (locked),
      .timeout     (timeout)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit valid;
      int per;
      bit lck;
      int to_rise;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // reference model: state of the lock rules, driven by tick times only
   int m_mode = M_IDLE;
   int m_good = 0;
   int t_prev = 0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic rise_and_hold(input int high);
      exp_t e;
      int   t_now;
      int   gap;
      t_now     = cyc + LAT;
      gap       = t_now - t_prev;
      e.to_rise = -1;
      if ((m_mode == M_ACQ || m_mode == M_LOCK) && gap > MAX_P + 1) begin
         e.to_rise = t_prev + MAX_P + 1;
         m_mode    = M_LOST;
      end
      e.cyc = t_now;
      if (m_mode == M_IDLE || m_mode == M_LOST) begin
         e.valid = 1'b0;
         e.per   = 0;
         m_mode  = M_ACQ;
         m_good  = 0;
      end else begin
         e.valid = 1'b1;
         e.per   = gap;
         if (gap >= MIN_P && gap <= MAX_P) begin
            m_good++;
            if (m_good >= LOCK_N) m_mode = M_LOCK;
         end else begin
            m_mode = M_ACQ;
            m_good = 0;
         end
      end
      e.lck  = (m_mode == M_LOCK);
      t_prev = t_now;
      sb_q.push_back(e);
      refreshIn = 1'b1;
      step(high);
   endtask

   task automatic edge_gap(input int gap, input int high);
      rise_and_hold(high);
      refreshIn = 1'b0;
      step(gap - high);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tick"}, int'(tick), 0);
      check({tag, "_period"}, int'(period), 0);
      check({tag, "_periodValid"}, int'(periodValid), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_timeout"}, int'(timeout), 0);
   endtask

   // monitor
   int   to_rises = 0;
   int   to_rise_cyc = -1;
   bit   to_prev = 1'b0;
   exp_t got;

   always @(negedge clock) begin
      if (!reset) begin
         to_rises = 0;
         to_prev  = 1'b0;
      end else begin
         if (timeout && !to_prev) begin
            to_rises++;
            to_rise_cyc = cyc;
         end
         to_prev = timeout;
         if (periodValid && !tick) check("valid_without_tick", int'(periodValid), 0);
         if (timeout) check("locked_while_lost", int'(locked), 0);
         if (tick) begin
            if (sb_q.size() == 0) begin
               check("unexpected_tick", int'(tick), 0);
            end else begin
               got = sb_q.pop_front();
               check("tick_cycle", cyc, got.cyc);
               check("periodValid", int'(periodValid), int'(got.valid));
               if (got.valid) check("period", int'(period), got.per);
               check("locked", int'(locked), int'(got.lck));
               check("timeout_at_tick", int'(timeout), 0);
               check("timeout_rises", to_rises, (got.to_rise >= 0) ? 1 : 0);
               if (got.to_rise >= 0 && to_rises == 1)
                  check("timeout_cycle", to_rise_cyc, got.to_rise);
            end
            to_rises = 0;
         end
      end
   end

   initial begin : stim
      int g;
      int h;
      int exp_rises;
      reset     = 1'b0;
      refreshIn = 1'b0;
      step(3);
      check_all_zero("reset");
      reset = 1'b1;
      step(4);

      // steady 10-clock rate: lock after the third tick
      edge_gap(10, 5);
      edge_gap(10, 5);
      edge_gap(10, 5);
      // short period unlocks, two good periods relock
      edge_gap(6, 3);
      edge_gap(10, 5);
      edge_gap(10, 5);
      // upper boundary accepted, one past it rejected with no timeout
      edge_gap(12, 6);
      edge_gap(13, 6);
      edge_gap(10, 5);
      edge_gap(10, 5);
      // long held-high gap: single tick, then timeout before the next edge
      edge_gap(25, 22);
      edge_gap(10, 5);
      edge_gap(8, 4);
      edge_gap(7, 3);
      edge_gap(14, 7);
      edge_gap(10, 5);
      edge_gap(10, 5);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) g = $urandom_range(14, 30);
         else g = $urandom_range(3, 16);
         h = $urandom_range(1, g - 1);
         edge_gap(g, h);
      end

      // relock, then reset while refreshIn is high
      edge_gap(10, 5);
      edge_gap(10, 5);
      edge_gap(10, 5);
      rise_and_hold(6);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      m_mode = M_IDLE;
      m_good = 0;
      step(3);
      #2;
      reset = 1'b1;
      step(10);
      refreshIn = 1'b0;
      step(5);
      edge_gap(10, 5);
      edge_gap(11, 5);
      refreshIn = 1'b0;
      step(40);

      exp_rises = (m_mode == M_ACQ || m_mode == M_LOCK) ? 1 : 0;
      check("final_timeout_rises", to_rises, exp_rises);
      if (exp_rises == 1 && to_rises == 1)
         check("final_timeout_cycle", to_rise_cyc, t_prev + MAX_P + 1);
      check("pending_ticks", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
